// File: rtl/if_stage_day15.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID.
// Handles stall, branch redirect/flush and HALT suspension.
module if_stage_day15 #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               halted,
  output logic [7:0]         fetch_count
);

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic {
    RUN_S,
    HALT_S
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  if_id_t          ifid_q, ifid_d;
  logic [7:0]      cnt_q, cnt_d;

  logic is_halt;
  logic do_branch;
  logic do_stall;
  logic do_idle;
  logic do_fetch;

  assign is_halt = imem_data[INSTR_W-1 -: 4] == 4'hF;

  // Mutually exclusive qualifiers encode branch > stall > halted > fetch.
  assign do_branch = branch_taken;
  assign do_stall  = !branch_taken && stall;
  assign do_idle   = !branch_taken && !stall && state_q == HALT_S;
  assign do_fetch  = !branch_taken && !stall && state_q == RUN_S;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      do_branch: begin
        pc_d         = branch_target;
        ifid_d.instr = NOP;
        ifid_d.valid = 1'b0;
        state_d      = RUN_S;
      end
      do_stall: begin
      end
      do_idle: begin
        ifid_d.instr = NOP;
        ifid_d.valid = 1'b0;
      end
      do_fetch: begin
        ifid_d.instr = imem_data;
        ifid_d.pc    = pc_q;
        ifid_d.valid = 1'b1;
        cnt_d        = cnt_q + 8'd1;
        if (is_halt) begin
          state_d = HALT_S;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN_S;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP, pc: '0, valid: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_valid  = ifid_q.valid;
  assign halted      = state_q == HALT_S;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage_day15.sv
// Bench for if_stage_day15: reference model feeds a scoreboard queue,
// each edge pops one expected snapshot and compares every output.
module tb_if_stage_day15;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  pc;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [7:0]  fetch_count;

  logic [15:0] imem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic        valid;
    logic        halted;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  logic        m_halt;
  logic [7:0]  m_cnt;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  if_stage_day15 dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .pc(pc),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model advances one edge and queues the expected outputs.
  task automatic model(input logic r, input logic s, input logic b,
                       input logic [7:0] t);
    exp_t e;
    logic [15:0] w;
    if (r) begin
      m_pc = 8'h00; m_instr = '0; m_ipc = '0;
      m_valid = 0; m_halt = 0; m_cnt = '0;
    end else if (b) begin
      m_pc = t; m_instr = '0; m_valid = 0; m_halt = 0;
    end else if (s) begin
    end else if (m_halt) begin
      m_instr = '0; m_valid = 0;
    end else begin
      w = imem[m_pc];
      m_instr = w; m_ipc = m_pc; m_valid = 1;
      m_cnt = m_cnt + 8'd1;
      if (w[15:12] == 4'hF) m_halt = 1;
      else m_pc = m_pc + 8'd1;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc;
    e.valid = m_valid; e.halted = m_halt; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [7:0] t);
    exp_t e;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    model(r, s, b, t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("ifid_instr", ifid_instr, e.instr);
      if (e.valid) chk("ifid_pc", ifid_pc, e.ipc);
      chk("ifid_valid", ifid_valid, e.valid);
      chk("halted", halted, e.halted);
      chk("fetch_count", fetch_count, e.cnt);
    end
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halt = 0; m_cnt = 0;

    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_instr", ifid_instr, 16'h0000);

    fetch(3);
    chk("sl_pc", pc, 8'd3);
    chk("sl_instr", ifid_instr, 16'h1002);
    chk("sl_ipc", ifid_pc, 8'd2);
    chk("sl_cnt", fetch_count, 8'd3);

    fetch(2);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    chk("stall_pc", pc, 8'd5);
    chk("stall_instr", ifid_instr, 16'h1004);
    fetch(1);
    chk("unstall_instr", ifid_instr, 16'h1005);
    chk("unstall_pc", pc, 8'd6);

    fetch(1);
    cyc(0, 0, 1, 8'h40);
    chk("br_pc", pc, 8'h40);
    chk("br_bubble", ifid_valid, 0);
    fetch(1);
    chk("br_tgt_instr", ifid_instr, 16'h1040);
    chk("br_tgt_ipc", ifid_pc, 8'h40);

    fetch(2);
    cyc(0, 1, 1, 8'h20);
    chk("sb_pc", pc, 8'h20);
    chk("sb_flush", ifid_valid, 0);
    fetch(2);

    imem[4] = 16'hF000;
    cyc(0, 0, 1, 8'h02);
    fetch(3);
    chk("halt_instr", ifid_instr, 16'hF000);
    chk("halt_valid", ifid_valid, 1);
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 8'd4);
    fetch(2);
    chk("halt_bubble", ifid_valid, 0);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h10);
    chk("halt_clear", halted, 0);
    fetch(2);
    chk("resume_instr", ifid_instr, 16'h1011);

    cyc(0, 0, 1, 8'hFF);
    fetch(1);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_ipc", ifid_pc, 8'hFF);
    fetch(2);
    cyc(1, 1, 1, 8'h33);
    chk("rst_mid_pc", pc, 8'h00);
    chk("rst_mid_cnt", fetch_count, 8'h00);
    fetch(2);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          8'($urandom_range(0, 255)));
    end

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage_day15.md
# if_stage_day15

Instruction-fetch stage of the day-15 pipelined core, sitting directly upstream of the decode/execute stages that carry the EX/MEM and MEM/WB forwarding paths. It owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. Stall, branch-redirect/flush and HALT handling are applied here so that downstream stages see only NOPs or valid instructions.

## Interface
- PC_W, 8, program counter / instruction memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  hold PC and IF/ID (load-use hazard from decode)
- branch_taken  input  1  redirect request from EX
- branch_target  input  PC_W  redirect address
- imem_addr  output  PC_W  instruction memory address, combinational = pc
- imem_data  input  INSTR_W  instruction at imem_addr, combinational read
- pc  output  PC_W  current fetch PC
- ifid_instr  output  INSTR_W  IF/ID instruction register
- ifid_pc  output  PC_W  PC of ifid_instr
- ifid_valid  output  1  ifid_instr is a real instruction (0 = bubble)
- halted  output  1  HALT fetched; fetch suspended
- fetch_count  output  8  count of instructions accepted into IF/ID

## Operation
- Encodings: NOP = 16'h0000; HALT = imem_data[15:12] == 4'hF.
- Per-edge priority: rst > branch_taken > stall > halted > normal fetch.
- rst: pc=RESET_PC, ifid_instr=NOP, ifid_pc=0, ifid_valid=0, halted=0, fetch_count=0.
- branch_taken (regardless of stall/halted): pc<=branch_target; ifid_instr<=NOP, ifid_valid<=0 (flush wrong-path instruction); halted<=0; fetch_count unchanged.
- stall (no branch): pc, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count all hold.
- halted (no branch, no stall): pc holds; ifid_instr<=NOP, ifid_valid<=0; count holds.
- Normal fetch: ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1, fetch_count<=fetch_count+1 (mod 256).
  - Non-HALT: pc<=pc+1, modulo 2^PC_W (8'hFF -> 8'h00).
  - HALT: pc holds at HALT address, halted<=1; HALT itself enters IF/ID valid.
- States: RUN (halted=0) and HALT (halted=1). RUN->HALT on normal fetch of HALT; HALT->RUN only on branch_taken or rst.

## Timing
- imem_addr tracks pc combinationally, same cycle.
- Fetch latency: instruction at address A appears on ifid_instr one edge after pc==A and no stall/branch.
- Branch penalty: one bubble (ifid_valid=0) the cycle after branch_taken; target instruction in IF/ID one edge later.
- stall held N cycles: outputs frozen exactly N cycles; fetch resumes on first edge with stall=0.
- Stall and branch same cycle: branch wins.
- rst asserted mid-run overrides everything on that edge; first fetch from RESET_PC on first edge after rst deasserts.

## Test plan
- Reset then straight-line fetch, imem[i]=16'h1000+i: after 3 edges pc=3, ifid_instr=16'h1002, ifid_pc=2, ifid_valid=1, fetch_count=3.
- stall high 2 cycles at pc=5: pc stays 5, ifid_instr stays 16'h1004 for 2 cycles; next edge ifid_instr=16'h1005, pc=6.
- branch_taken with branch_target=8'h40 at pc=7: next edge pc=8'h40, ifid_valid=0, ifid_instr=0; following edge ifid_instr=imem[0x40], ifid_pc=8'h40.
- stall and branch_taken both high (target 8'h20): branch wins, pc=8'h20, IF/ID flushed.
- HALT (16'hF000) at addr 4: ifid_instr=16'hF000 valid, halted=1, pc holds 4, then NOP bubbles; branch to 8'h10 clears halted and resumes.
- PC wrap: branch to 8'hFF, fetch: pc=8'h00, ifid_pc=8'hFF; rst mid-run returns all outputs to reset values on next edge.
